// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipelined controller: opcode map, control-word
// bit positions and forwarding-select encodings.
package pipeline_controller_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_DIV   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9,
    OP_BEQ   = 4'hA,
    OP_JMP   = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_NOP   = 4'hF
  } opcode_e;

  // Bit positions inside the control word carried in ID/EX.
  localparam int CW_REG_WRITE = 0;
  localparam int CW_MEM_READ  = 1;
  localparam int CW_MEM_WRITE = 2;
  localparam int CW_BRANCH    = 3;
  localparam int CW_ILLEGAL   = 4;
  localparam int CW_W         = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

endpackage

// File: rtl/pipeline_controller_forward_unit.sv
// Operand forwarding select for one EX source register; the younger
// producer in EX/MEM wins over the older one in MEM/WB.
module forward_unit
  import pipeline_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output logic [1:0]            fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
      fwd = FWD_EXMEM;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
      fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline controller: ID decode, ID/EX..MEM/WB control registers,
// load-use and multi-cycle DIV hazards, branch flush and operand forwarding.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 4,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [OPCODE_W-1:0]   ex_alu_op,
  output logic                  ex_illegal,
  output logic                  div_busy,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef struct packed {
    logic [CW_W-1:0]       ctrl;
    logic [OPCODE_W-1:0]   op;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t     dec, id_ex, id_ex_d;
  ex_mem_t    ex_mem, ex_mem_d;
  mem_wb_t    mem_wb, mem_wb_d;
  logic [CNT_W-1:0] div_cnt, div_cnt_d;
  logic       load_use, branch_qual;

  // ID decode; an empty ID slot decodes to an all-zero bubble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec = '0;
    if (id_valid) begin
      dec.op  = id_opcode;
      dec.rs1 = id_rs1;
      dec.rs2 = id_rs2;
      dec.rd  = id_rd;
      if (id_opcode <= OPCODE_W'(OP_NOT)) begin
        dec.ctrl[CW_REG_WRITE] = 1'b1;
      end else if (id_opcode == OPCODE_W'(OP_LOAD)) begin
        dec.ctrl[CW_REG_WRITE] = 1'b1;
        dec.ctrl[CW_MEM_READ]  = 1'b1;
      end else if (id_opcode == OPCODE_W'(OP_STORE)) begin
        dec.ctrl[CW_MEM_WRITE] = 1'b1;
      end else if ((id_opcode == OPCODE_W'(OP_BEQ)) || (id_opcode == OPCODE_W'(OP_JMP))) begin
        dec.ctrl[CW_BRANCH] = 1'b1;
      end else if ((id_opcode >= OPCODE_W'(OP_RSV_C)) && (id_opcode <= OPCODE_W'(OP_RSV_E))) begin
        dec.ctrl[CW_ILLEGAL] = 1'b1;
      end
      if (id_rd == '0) dec.ctrl[CW_REG_WRITE] = 1'b0;
    end
  end

  assign div_busy    = (div_cnt != '0);
  assign branch_qual = branch_taken && id_ex.ctrl[CW_BRANCH];
  assign load_use    = id_ex.ctrl[CW_MEM_READ] && (id_ex.rd != '0) && id_valid &&
                       ((id_ex.rd == id_rs1) || (id_ex.rd == id_rs2));
  assign stall       = (load_use && !branch_qual) || div_busy;
  assign flush       = branch_qual;

  // A busy DIV freezes ID/EX; otherwise a hazard or taken branch inserts a bubble.
  always_comb begin
    id_ex_d   = dec;
    div_cnt_d = '0;
    if (div_busy) begin
      id_ex_d   = id_ex;
      div_cnt_d = div_cnt - CNT_W'(1);
    end else if (branch_qual || load_use) begin
      id_ex_d = '0;
    end else if (dec.op == OPCODE_W'(OP_DIV)) begin
      div_cnt_d = CNT_W'(DIV_CYCLES - 1);
    end
  end

  always_comb begin
    ex_mem_d = '0;
    if (!div_busy) begin
      ex_mem_d.reg_write = id_ex.ctrl[CW_REG_WRITE];
      ex_mem_d.mem_read  = id_ex.ctrl[CW_MEM_READ];
      ex_mem_d.mem_write = id_ex.ctrl[CW_MEM_WRITE];
      ex_mem_d.rd        = id_ex.rd;
    end
  end

  always_comb begin
    mem_wb_d.reg_write = ex_mem.reg_write;
    mem_wb_d.rd        = ex_mem.rd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex   <= '0;
      ex_mem  <= '0;
      mem_wb  <= '0;
      div_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      id_ex   <= id_ex_d;
      ex_mem  <= ex_mem_d;
      mem_wb  <= mem_wb_d;
      div_cnt <= div_cnt_d;
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs              (id_ex.rs1),
    .exmem_reg_write (ex_mem.reg_write),
    .exmem_rd        (ex_mem.rd),
    .memwb_reg_write (mem_wb.reg_write),
    .memwb_rd        (mem_wb.rd),
    .fwd             (fwd_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs              (id_ex.rs2),
    .exmem_reg_write (ex_mem.reg_write),
    .exmem_rd        (ex_mem.rd),
    .memwb_reg_write (mem_wb.reg_write),
    .memwb_rd        (mem_wb.rd),
    .fwd             (fwd_b)
  );

  assign ex_alu_op     = id_ex.op;
  assign ex_illegal    = id_ex.ctrl[CW_ILLEGAL];
  assign mem_mem_read  = ex_mem.mem_read;
  assign mem_mem_write = ex_mem.mem_write;
  assign wb_reg_write  = mem_wb.reg_write;
  assign wb_rd         = mem_wb.rd;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: an instruction-level model of the pipeline
// checked every cycle, plus directed scenarios with hand-derived expectations.
module tb_pipeline_controller;

  localparam int DC = 4;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, DIV = 4'h3, XOR = 4'h6, OR_ = 4'h5;
  localparam logic [3:0] LOAD = 4'h8, STORE = 4'h9, BEQ = 4'hA, JMP = 4'hB, NOP = 4'hF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_opcode = '0, id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       branch_taken = 1'b0;
  logic       stall, flush, ex_illegal, div_busy, mem_mem_read, mem_mem_write, wb_reg_write;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] ex_alu_op, wb_rd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  pipeline_controller #(.OPCODE_W(4), .REG_ADDR_W(4), .DIV_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal), .div_busy(div_busy),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd)
  );

  always #5 clock = ~clock;

  // Instruction-level model: one slot per stage, rem = extra EX cycles left.
  typedef struct {
    logic       valid;
    logic [3:0] op, rs1, rs2, rd;
    int         rem;
  } ins_t;

  ins_t m_ex, m_mem, m_wb, cur_id;
  ins_t prog[$];

  function automatic ins_t bubble();
    ins_t b;
    b.valid = 1'b0; b.op = '0; b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.rem = 0;
    return b;
  endfunction

  function automatic ins_t mk(logic [3:0] op, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
    ins_t b;
    b = bubble();
    b.valid = 1'b1; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    return b;
  endfunction

  function automatic ins_t fetch();
    if (prog.size() != 0) return prog.pop_front();
    return bubble();
  endfunction

  function automatic logic is_op(ins_t i, logic [3:0] op);
    return i.valid && (i.op == op);
  endfunction

  function automatic logic writes(ins_t i);
    return i.valid && (i.op <= LOAD) && (i.rd != 4'h0);
  endfunction

  function automatic logic [1:0] exp_fwd(logic [3:0] rs);
    if (!m_ex.valid) return 2'b00;
    if (writes(m_mem) && (m_mem.rd == rs)) return 2'b01;
    if (writes(m_wb) && (m_wb.rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [18:0] outs();
    return {stall, flush, fwd_a, fwd_b, ex_alu_op, ex_illegal, div_busy,
            mem_mem_read, mem_mem_write, wb_reg_write, wb_rd};
  endfunction

  task automatic model_clear();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); cur_id = bubble();
    prog.delete();
  endtask

  // One clock: drive ID, compare every output to the model, then advance it.
  task automatic cycle(input string tag, input logic bt);
    logic e_lu, e_fl, e_db, e_st;
    logic [18:0] exp_v, obs_v;
    @(negedge clock);
    cyc++;
    id_valid = cur_id.valid; id_opcode = cur_id.op;
    id_rs1 = cur_id.rs1; id_rs2 = cur_id.rs2; id_rd = cur_id.rd;
    branch_taken = bt;
    #1;
    e_lu = is_op(m_ex, LOAD) && (m_ex.rd != 4'h0) && cur_id.valid &&
           ((m_ex.rd == cur_id.rs1) || (m_ex.rd == cur_id.rs2));
    e_fl = bt && (is_op(m_ex, BEQ) || is_op(m_ex, JMP));
    e_db = is_op(m_ex, DIV) && (m_ex.rem > 0);
    e_st = (e_lu && !e_fl) || e_db;
    exp_v = {e_st, e_fl, exp_fwd(m_ex.rs1), exp_fwd(m_ex.rs2),
             (m_ex.valid ? m_ex.op : 4'h0),
             (m_ex.valid && (m_ex.op >= 4'hC) && (m_ex.op <= 4'hE)), e_db,
             is_op(m_mem, LOAD), is_op(m_mem, STORE), writes(m_wb),
             (m_wb.valid ? m_wb.rd : 4'h0)};
    obs_v = outs();
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s cycle %0d {stall,flush,fa,fb,op,ill,busy,mrd,mwr,wbw,wbrd}: got %b want %b",
               tag, cyc, obs_v, exp_v);
    end
    m_wb = m_mem;
    m_mem = e_db ? bubble() : m_ex;
    if (e_db) m_ex.rem--;
    else if (e_fl || e_lu) m_ex = bubble();
    else begin
      m_ex = cur_id;
      m_ex.rem = is_op(cur_id, DIV) ? DC - 1 : 0;
    end
    if (e_fl || !e_st) cur_id = fetch();
  endtask

  task automatic drain();
    prog.delete();
    cur_id = bubble();
    repeat (9) cycle("drain", 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    id_valid = 1'b1; id_opcode = LOAD; id_rs1 = 4'h3; id_rs2 = 4'h3; id_rd = 4'h3;
    branch_taken = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (outs() !== 19'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want all zero", outs());
    end
    model_clear();
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_load_use();
    drain();
    prog.push_back(mk(LOAD, 4'h3, 4'h1, 4'h2));
    prog.push_back(mk(ADD, 4'h4, 4'h3, 4'h1));
    cur_id = fetch();
    cycle("lu", 1'b0);
    cycle("lu", 1'b0);
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: stall=%b want 1", stall); end
    cycle("lu", 1'b0);
    n_checks++;
    if ({stall, ex_alu_op, mem_mem_read} !== {1'b0, 4'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL lu_bubble: stall=%b ex_op=%h mem_read=%b want 0 0 1", stall, ex_alu_op, mem_mem_read);
    end
    cycle("lu", 1'b0);
    n_checks++;
    if ({ex_alu_op, fwd_a, fwd_b} !== {ADD, 2'b10, 2'b00}) begin
      n_errors++;
      $display("FAIL lu_fwd: ex_op=%h fwd_a=%b fwd_b=%b want 0 10 00", ex_alu_op, fwd_a, fwd_b);
    end
  endtask

  task automatic test_forward_priority();
    drain();
    prog.push_back(mk(ADD, 4'h5, 4'h1, 4'h2));
    prog.push_back(mk(SUB, 4'h5, 4'h2, 4'h3));
    prog.push_back(mk(OR_, 4'h6, 4'h5, 4'h5));
    cur_id = fetch();
    repeat (4) cycle("fwd", 1'b0);
    n_checks++;
    if ({ex_alu_op, fwd_a, fwd_b} !== {OR_, 2'b01, 2'b01}) begin
      n_errors++;
      $display("FAIL fwd_priority: ex_op=%h fwd_a=%b fwd_b=%b want 5 01 01", ex_alu_op, fwd_a, fwd_b);
    end
  endtask

  task automatic test_r0();
    drain();
    prog.push_back(mk(ADD, 4'h0, 4'h1, 4'h2));
    prog.push_back(mk(XOR, 4'h7, 4'h0, 4'h0));
    cur_id = fetch();
    repeat (3) cycle("r0", 1'b0);
    n_checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_errors++;
      $display("FAIL r0_fwd: fwd_a=%b fwd_b=%b want 00 00", fwd_a, fwd_b);
    end
    cycle("r0", 1'b0);
    n_checks++;
    if ({wb_reg_write, wb_rd} !== 5'b0) begin
      n_errors++;
      $display("FAIL r0_wb: wb_reg_write=%b wb_rd=%h want 0 0", wb_reg_write, wb_rd);
    end
  endtask

  task automatic test_back_to_back_div();
    logic [11:0] st_vec;
    logic [3:0]  wb_at [12];
    logic        wbw_at [12];
    drain();
    prog.push_back(mk(DIV, 4'h9, 4'h1, 4'h2));
    prog.push_back(mk(DIV, 4'hA, 4'h3, 4'h4));
    cur_id = fetch();
    for (int i = 0; i < 12; i++) begin
      cycle("div", 1'b0);
      st_vec[i] = stall;
      wb_at[i]  = wb_rd;
      wbw_at[i] = wb_reg_write;
    end
    n_checks++;
    if (st_vec !== 12'b0000_1110_1110) begin
      n_errors++;
      $display("FAIL div_stall_pattern: got %b want 000011101110", st_vec);
    end
    n_checks++;
    if ({wbw_at[6], wb_at[6], wbw_at[10], wb_at[10]} !== {1'b1, 4'h9, 1'b1, 4'hA}) begin
      n_errors++;
      $display("FAIL div_wb_timing: c7=%b/%h c11=%b/%h want 1/9 1/a",
               wbw_at[6], wb_at[6], wbw_at[10], wb_at[10]);
    end
  endtask

  task automatic test_branch_flush();
    drain();
    prog.push_back(mk(LOAD, 4'h3, 4'h1, 4'h2));
    prog.push_back(mk(BEQ, 4'h0, 4'h3, 4'h1));
    prog.push_back(mk(SUB, 4'h6, 4'h3, 4'h3));
    prog.push_back(mk(NOP, 4'h0, 4'h0, 4'h0));
    cur_id = fetch();
    repeat (3) cycle("br", 1'b0);
    cycle("br", 1'b1);
    n_checks++;
    if ({ex_alu_op, flush, stall} !== {BEQ, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL br_flush: ex_op=%h flush=%b stall=%b want a 1 0", ex_alu_op, flush, stall);
    end
    cycle("br", 1'b0);
    n_checks++;
    if ({ex_alu_op, flush} !== {4'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL br_bubble: ex_op=%h flush=%b want 0 0", ex_alu_op, flush);
    end
  endtask

  task automatic test_random();
    int guard;
    drain();
    for (int i = 0; i < 600; i++) begin
      ins_t r;
      r = bubble();
      r.valid = ($urandom_range(0, 9) != 0);
      r.op  = 4'($urandom_range(0, 15));
      r.rd  = 4'($urandom_range(0, 4));
      r.rs1 = 4'($urandom_range(0, 4));
      r.rs2 = 4'($urandom_range(0, 4));
      prog.push_back(r);
    end
    cur_id = fetch();
    guard = 0;
    while ((prog.size() != 0) && (guard < 5000)) begin
      cycle("rand", 1'($urandom_range(0, 1)));
      guard++;
    end
    n_checks++;
    if (prog.size() != 0) begin
      n_errors++;
      $display("FAIL rand_progress: %0d instructions left after %0d cycles, want 0", prog.size(), guard);
    end
  endtask

  task automatic test_reset_mid_div();
    drain();
    prog.push_back(mk(DIV, 4'h5, 4'h1, 4'h2));
    cur_id = fetch();
    cycle("rdiv", 1'b0);
    cycle("rdiv", 1'b0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 19'b0) begin
      n_errors++;
      $display("FAIL reset_mid_div: got %b want all zero", outs());
    end
    model_clear();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) prog.push_back(mk(NOP, 4'h0, 4'h0, 4'h0));
    prog.push_back(mk(4'hD, 4'h2, 4'h1, 4'h1));
    cur_id = fetch();
    for (int i = 1; i <= 9; i++) begin
      cycle("post_reset", 1'b0);
      n_checks++;
      if (stall !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_stall: cycle %0d stall=%b want 0", i, stall);
      end
      if (i == 8) begin
        n_checks++;
        if ({ex_alu_op, ex_illegal} !== {4'hD, 1'b1}) begin
          n_errors++;
          $display("FAIL illegal_d: ex_op=%h ex_illegal=%b want d 1", ex_alu_op, ex_illegal);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_forward_priority();
    test_r0();
    test_back_to_back_div();
    test_branch_flush();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
